// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: load alignment/extension, stall/flush control,
// write-back mux and retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  cnt_clr,
  input  logic                  valid_in,
  input  logic [1:0]            control_wb_in,
  input  logic [2:0]            load_type_in,
  input  logic [DATA_W-1:0]     Read_data_in,
  input  logic [DATA_W-1:0]     ALU_result_in,
  input  logic [REG_ADDR_W-1:0] Write_reg_in,
  output logic                  mem_valid,
  output logic [1:0]            mem_control_wb,
  output logic [DATA_W-1:0]     Read_data,
  output logic [DATA_W-1:0]     mem_ALU_result,
  output logic [REG_ADDR_W-1:0] mem_Write_reg,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_reg_write,
  output logic [CNT_W-1:0]      retired_count
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam logic [OFF_W-1:0] HMASK = ~OFF_W'(1);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  off_h;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] ld_data;
  logic              is_lb;
  logic              is_lh;
  logic              is_lbu;
  logic              is_lhu;

  assign off      = ALU_result_in[OFF_W-1:0];
  assign off_h    = off & HMASK;
  assign byte_sel = Read_data_in[{off, 3'b000} +: 8];
  assign half_sel = Read_data_in[{off_h, 3'b000} +: 16];

  assign is_lb  = (load_type_in == LT_LB);
  assign is_lh  = (load_type_in == LT_LH);
  assign is_lbu = (load_type_in == LT_LBU);
  assign is_lhu = (load_type_in == LT_LHU);

  // Unlisted load codes fall through to a full-word load.
  always_comb begin
    ld_data = Read_data_in;
    unique case (1'b1)
      is_lb:   ld_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      is_lh:   ld_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      is_lbu:  ld_data = {{(DATA_W-8){1'b0}}, byte_sel};
      is_lhu:  ld_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: ld_data = Read_data_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_control_wb <= 2'b00;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_control_wb <= 2'b00;
    end else if (!stall) begin
      mem_valid      <= valid_in;
      mem_control_wb <= control_wb_in;
    end
  end

  // Data registers keep their contents across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Read_data      <= '0;
      mem_ALU_result <= '0;
      mem_Write_reg  <= '0;
    end else if (!stall && !flush) begin
      Read_data      <= ld_data;
      mem_ALU_result <= ALU_result_in;
      mem_Write_reg  <= Write_reg_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (cnt_clr) begin
      retired_count <= '0;
    end else if (mem_valid && !stall) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

  assign wb_data      = mem_control_wb[0] ? Read_data : mem_ALU_result;
  assign wb_reg_write = mem_valid & mem_control_wb[1] &
                        (mem_Write_reg != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: default, 4-bit counter
// and 64-bit datapath instances.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        cnt_clr;
  logic        valid;
  logic [1:0]  ctrl;
  logic [2:0]  lt;
  logic [31:0] rd;
  logic [31:0] alu;
  logic [4:0]  wr;
  logic [63:0] rd64;
  logic [63:0] alu64;

  logic        v32;
  logic [1:0]  c32;
  logic [31:0] r32;
  logic [31:0] a32;
  logic [4:0]  w32;
  logic [31:0] wbd32;
  logic        we32;
  logic [31:0] cnt32;

  logic        v4;
  logic [1:0]  c4;
  logic [31:0] r4;
  logic [31:0] a4;
  logic [4:0]  w4;
  logic [31:0] wbd4;
  logic        we4;
  logic [3:0]  cnt4;

  logic        v64;
  logic [1:0]  c64;
  logic [63:0] r64;
  logic [63:0] a64;
  logic [4:0]  w64;
  logic [63:0] wbd64;
  logic        we64;
  logic [31:0] cnt64;

  int total;
  int bad;

  mem_wb_stage u32 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .cnt_clr(cnt_clr), .valid_in(valid), .control_wb_in(ctrl),
    .load_type_in(lt), .Read_data_in(rd), .ALU_result_in(alu),
    .Write_reg_in(wr), .mem_valid(v32), .mem_control_wb(c32),
    .Read_data(r32), .mem_ALU_result(a32), .mem_Write_reg(w32),
    .wb_data(wbd32), .wb_reg_write(we32), .retired_count(cnt32)
  );

  mem_wb_stage #(.CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .cnt_clr(cnt_clr), .valid_in(valid), .control_wb_in(ctrl),
    .load_type_in(lt), .Read_data_in(rd), .ALU_result_in(alu),
    .Write_reg_in(wr), .mem_valid(v4), .mem_control_wb(c4),
    .Read_data(r4), .mem_ALU_result(a4), .mem_Write_reg(w4),
    .wb_data(wbd4), .wb_reg_write(we4), .retired_count(cnt4)
  );

  mem_wb_stage #(.DATA_W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .cnt_clr(cnt_clr), .valid_in(valid), .control_wb_in(ctrl),
    .load_type_in(lt), .Read_data_in(rd64), .ALU_result_in(alu64),
    .Write_reg_in(wr), .mem_valid(v64), .mem_control_wb(c64),
    .Read_data(r64), .mem_ALU_result(a64), .mem_Write_reg(w64),
    .wb_data(wbd64), .wb_reg_write(we64), .retired_count(cnt64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (v32 !== 1'b0 || c32 !== 2'b00 || r32 !== 32'h0 ||
        a32 !== 32'h0 || w32 !== 5'h0 || cnt32 !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs got v=%b c=%b r=%h a=%h w=%h n=%h exp all 0",
               v32, c32, r32, a32, w32, cnt32);
    end
    total++;
    if (wbd32 !== 32'h0 || we32 !== 1'b0) begin
      bad++;
      $display("FAIL reset_wb got d=%h we=%b exp 0", wbd32, we32);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_ext();
    valid = 1'b1; ctrl = 2'b11; wr = 5'd1;
    rd = 32'h80FF7F01;
    lt = 3'b000; alu = 32'h3;
    step();
    total++;
    if (r32 !== 32'hFFFFFF80) begin
      bad++; $display("FAIL lb_off3 got=%h exp=%h", r32, 32'hFFFFFF80);
    end
    total++;
    if (a32 !== 32'h3 || v32 !== 1'b1) begin
      bad++; $display("FAIL lb_alu got a=%h v=%b exp a=3 v=1", a32, v32);
    end
    lt = 3'b100; alu = 32'h1;
    step();
    total++;
    if (r32 !== 32'h0000007F) begin
      bad++; $display("FAIL lbu_off1 got=%h exp=%h", r32, 32'h7F);
    end
    lt = 3'b001; alu = 32'h3;
    step();
    total++;
    if (r32 !== 32'hFFFF80FF) begin
      bad++; $display("FAIL lh_off3 got=%h exp=%h", r32, 32'hFFFF80FF);
    end
    lt = 3'b101; alu = 32'h0;
    step();
    total++;
    if (r32 !== 32'h00007F01) begin
      bad++; $display("FAIL lhu_off0 got=%h exp=%h", r32, 32'h7F01);
    end
    lt = 3'b010; alu = 32'h2;
    step();
    total++;
    if (r32 !== 32'h80FF7F01) begin
      bad++; $display("FAIL lw got=%h exp=%h", r32, 32'h80FF7F01);
    end
    lt = 3'b111; alu = 32'h1;
    step();
    total++;
    if (r32 !== 32'h80FF7F01) begin
      bad++; $display("FAIL lt_other got=%h exp=%h", r32, 32'h80FF7F01);
    end
    lt = 3'b000; alu = 32'h1;
    step();
    total++;
    if (r32 !== 32'h0000007F) begin
      bad++; $display("FAIL lb_off1 got=%h exp=%h", r32, 32'h7F);
    end
  endtask

  task automatic test_wb_mux();
    valid = 1'b1; lt = 3'b010;
    rd = 32'h12345678; alu = 32'h00000100;
    ctrl = 2'b11; wr = 5'd5;
    step();
    total++;
    if (wbd32 !== 32'h12345678 || we32 !== 1'b1) begin
      bad++;
      $display("FAIL wb_load got d=%h we=%b exp d=12345678 we=1",
               wbd32, we32);
    end
    wr = 5'd0;
    step();
    total++;
    if (we32 !== 1'b0 || wbd32 !== 32'h12345678) begin
      bad++;
      $display("FAIL wb_x0 got d=%h we=%b exp d=12345678 we=0",
               wbd32, we32);
    end
    ctrl = 2'b10; wr = 5'd5;
    step();
    total++;
    if (wbd32 !== 32'h00000100 || we32 !== 1'b1) begin
      bad++;
      $display("FAIL wb_alu got d=%h we=%b exp d=00000100 we=1",
               wbd32, we32);
    end
    valid = 1'b0;
    step();
    total++;
    if (we32 !== 1'b0 || v32 !== 1'b0) begin
      bad++;
      $display("FAIL wb_invalid got we=%b v=%b exp 0 0", we32, v32);
    end
    ctrl = 2'b01;
    step();
    total++;
    if (we32 !== 1'b0) begin
      bad++; $display("FAIL wb_norw got we=%b exp 0", we32);
    end
  endtask

  task automatic test_stall_flush();
    valid = 1'b1; ctrl = 2'b11; lt = 3'b010; wr = 5'd7;
    rd = 32'hA5A5C3C3; alu = 32'h44;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    total++;
    if (v32 !== 1'b1 || w32 !== 5'd7 || cnt32 !== 32'd0) begin
      bad++;
      $display("FAIL sf_loadA got v=%b w=%0d n=%0d exp v=1 w=7 n=0",
               v32, w32, cnt32);
    end
    stall = 1'b1;
    rd = 32'h11112222; alu = 32'h88; wr = 5'd9; ctrl = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (v32 !== 1'b1 || r32 !== 32'hA5A5C3C3 || a32 !== 32'h44 ||
          w32 !== 5'd7 || c32 !== 2'b11 || cnt32 !== 32'd0 ||
          we32 !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%b r=%h a=%h w=%0d c=%b n=%0d we=%b exp v=1 r=a5a5c3c3 a=44 w=7 c=11 n=0 we=1",
                 i, v32, r32, a32, w32, c32, cnt32, we32);
      end
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    total++;
    if (v32 !== 1'b0 || c32 !== 2'b00 || we32 !== 1'b0) begin
      bad++;
      $display("FAIL flush_ctrl got v=%b c=%b we=%b exp 0 00 0",
               v32, c32, we32);
    end
    total++;
    if (r32 !== 32'hA5A5C3C3 || a32 !== 32'h44 || w32 !== 5'd7 ||
        cnt32 !== 32'd0) begin
      bad++;
      $display("FAIL flush_data got r=%h a=%h w=%0d n=%0d exp r=a5a5c3c3 a=44 w=7 n=0",
               r32, a32, w32, cnt32);
    end
  endtask

  task automatic test_retire();
    ctrl = 2'b10; wr = 5'd3; valid = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    total++;
    if (cnt32 !== 32'd0 || cnt4 !== 4'd0) begin
      bad++;
      $display("FAIL cnt_clr got=%0d/%0d exp=0/0", cnt32, cnt4);
    end
    valid = 1'b1;
    repeat (10) step();
    valid = 1'b0;
    step();
    total++;
    if (cnt32 !== 32'd10 || cnt4 !== 4'd10) begin
      bad++;
      $display("FAIL retire10 got=%0d/%0d exp=10/10", cnt32, cnt4);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    valid = 1'b1;
    repeat (17) step();
    valid = 1'b0;
    step();
    total++;
    if (cnt4 !== 4'd1) begin
      bad++; $display("FAIL wrap4 got=%0d exp=1", cnt4);
    end
    total++;
    if (cnt32 !== 32'd17) begin
      bad++; $display("FAIL retire17 got=%0d exp=17", cnt32);
    end
    valid = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (cnt32 !== 32'd18 || v32 !== 1'b0) begin
      bad++;
      $display("FAIL flush_retire got n=%0d v=%b exp n=18 v=0", cnt32, v32);
    end
    valid = 1'b1;
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    total++;
    if (cnt32 !== 32'd0 || cnt4 !== 4'd0 || v32 !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_retire got=%0d/%0d v=%b exp=0/0 v=1",
               cnt32, cnt4, v32);
    end
    valid = 1'b0;
  endtask

  task automatic test_width64();
    valid = 1'b1; ctrl = 2'b11; wr = 5'd4;
    rd64 = 64'h8001_0000_0000_0000;
    lt = 3'b001; alu64 = 64'h6;
    step();
    total++;
    if (r64 !== 64'hFFFF_FFFF_FFFF_8001 || wbd64 !== r64) begin
      bad++;
      $display("FAIL w64_lh_off6 got=%h exp=%h", r64,
               64'hFFFF_FFFF_FFFF_8001);
    end
    lt = 3'b100; alu64 = 64'h7;
    step();
    total++;
    if (r64 !== 64'h0000_0000_0000_0080) begin
      bad++; $display("FAIL w64_lbu_off7 got=%h exp=%h", r64, 64'h80);
    end
    lt = 3'b000; alu64 = 64'h6;
    step();
    total++;
    if (r64 !== 64'h0000_0000_0000_0001) begin
      bad++; $display("FAIL w64_lb_off6 got=%h exp=%h", r64, 64'h1);
    end
  endtask

  task automatic test_async_reset();
    valid = 1'b1; ctrl = 2'b11; wr = 5'd3; lt = 3'b010;
    rd = 32'hDEADBEEF; alu = 32'h20;
    rd64 = 64'h1234; alu64 = 64'h8;
    step();
    total++;
    if (v32 !== 1'b1 || we32 !== 1'b1 || wbd32 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL pre_rst got v=%b we=%b d=%h exp 1 1 deadbeef",
               v32, we32, wbd32);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (v32 !== 1'b0 || c32 !== 2'b00 || r32 !== 32'h0 ||
        a32 !== 32'h0 || w32 !== 5'h0 || cnt32 !== 32'h0 ||
        wbd32 !== 32'h0 || we32 !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got v=%b c=%b r=%h a=%h w=%h n=%h d=%h we=%b exp all 0",
               v32, c32, r32, a32, w32, cnt32, wbd32, we32);
    end
    total++;
    if (v64 !== 1'b0 || r64 !== 64'h0 || cnt4 !== 4'h0) begin
      bad++;
      $display("FAIL async_rst_var got v64=%b r64=%h n4=%h exp 0",
               v64, r64, cnt4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (v32 !== 1'b1 || r32 !== 32'hDEADBEEF || cnt32 !== 32'd0) begin
      bad++;
      $display("FAIL post_rst got v=%b r=%h n=%0d exp v=1 r=deadbeef n=0",
               v32, r32, cnt32);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    valid = 1'b0; ctrl = 2'b00; lt = 3'b010; wr = 5'd0;
    rd = '0; alu = '0; rd64 = '0; alu64 = '0;
    test_reset();
    test_load_ext();
    test_wb_mux();
    test_stall_flush();
    test_retire();
    test_width64();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline stage between data-memory access and register-file write-back. Each instruction is captured with a valid bit, and the stage supports stall (hold) and flush (bubble). Load data is byte/halfword aligned and sign- or zero-extended before capture. The stage drives the final write-back data and register write enable, and keeps a retired-instruction counter.

## Interface

- DATA_W, 32: datapath width; multiple of 8, ≥ 16
- REG_ADDR_W, 5: destination register index width
- CNT_W, 32: retired-instruction counter width

Clock, reset and sequencing:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, active-low; one clock, asynchronous, active-low
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble instead of the incoming instruction
- cnt_clr  in  1  synchronous clear of retired_count

Inputs from the memory stage:
- valid_in  in  1  incoming instruction is real
- control_wb_in  in  2  [1]=RegWrite, [0]=MemtoReg
- load_type_in  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other code is treated as LW
- Read_data_in  in  DATA_W  raw memory read word
- ALU_result_in  in  DATA_W  ALU result / load address
- Write_reg_in  in  REG_ADDR_W  destination register

Outputs:
- mem_valid  out  1  stage holds a valid instruction
- mem_control_wb  out  2  registered control
- Read_data  out  DATA_W  registered, aligned and extended load data
- mem_ALU_result  out  DATA_W  registered ALU result
- mem_Write_reg  out  REG_ADDR_W  registered destination
- wb_data  out  DATA_W  write-back value
- wb_reg_write  out  1  register-file write enable
- retired_count  out  CNT_W  retired-instruction count

## Operation

- **Register update priority:** rst_n low, then flush, then stall, then load.
- **Reset:** while rst_n is low, every registered output is 0, including mem_valid, mem_control_wb, Read_data, mem_ALU_result, mem_Write_reg and retired_count. wb_data and wb_reg_write are therefore 0.
- **Flush:** on the edge, mem_valid←0 and mem_control_wb←0. Data registers keep their values. Flush overrides stall.
- **Stall (no flush):** every stage register holds its value.
- **Load:** every register captures its input; mem_valid←valid_in.
- **Alignment:**
  - OFF_W = log2(DATA_W/8); off = ALU_result_in[OFF_W-1:0]. Little-endian.
  - LB/LBU select byte Read_data_in[8·off +: 8].
  - LH/LHU select the halfword at off with bit 0 forced to 0. There is no misalignment trap.
  - LW passes the full DATA_W word.
  - LB and LH sign-extend to DATA_W; LBU and LHU zero-extend.
  - Alignment is applied before capture.
- **Write-back mux (combinational from registers):** wb_data = mem_control_wb[0] ? Read_data : mem_ALU_result.
- **Write enable:** wb_reg_write = mem_valid & mem_control_wb[1] & (mem_Write_reg ≠ 0).
- **Retire counter:**
  - Increments by 1 on each edge where mem_valid=1 and stall=0. Flush does not block retirement of the current occupant.
  - cnt_clr has priority over increment, and the counter reads 0 after the edge.
  - Wraps from 2^CNT_W−1 to 0.

## Timing

- Latency is 1 cycle from inputs to registered outputs. wb_data and wb_reg_write are valid in the same cycle as the registered outputs, with no extra flop.
- Under stall, wb_reg_write stays asserted for the held instruction every cycle. Repeated writes of the same value are acceptable.
- stall and flush are sampled only at the rising edge. A flush in cycle N gives mem_valid=0 in cycle N+1.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock. After rst_n rises, the first edge performs a normal update.
- Simultaneous stall and flush behave as flush.
- Simultaneous cnt_clr and a retire event leave the counter at 0.

## Test plan

- **Reset:** assert rst_n=0 asynchronously between edges with valid data loaded → all outputs 0 immediately; wb_reg_write=0.
- **Load extension:** Read_data_in=0x80FF7F01, LB with off=3 → Read_data=0xFFFFFF80. LBU with off=1 → 0x0000007F. LH with off=3 → 0xFFFF80FF. LHU with off=0 → 0x00007F01. LW → 0x80FF7F01.
- **Write-back mux and enable:** control_wb_in=2'b11, Write_reg_in=5 → wb_data=Read_data and wb_reg_write=1. Same with Write_reg_in=0 → wb_reg_write=0. control_wb_in=2'b10 → wb_data=mem_ALU_result.
- **Stall then flush:** load instruction A, then stall for 3 cycles → outputs hold A and retired_count is unchanged. Then raise stall and flush together → mem_valid=0 next cycle, data registers still hold A's values, and retired_count unchanged.
- **Retire counter:** 10 back-to-back valid instructions with no stall → retired_count=10. With CNT_W=4 and 17 retirements → reads 1. cnt_clr on the same edge as a retire → reads 0.
- **Width variant:** DATA_W=64, LH with off=6 on 0x8001_0000_0000_0000 → Read_data=0xFFFF_FFFF_FFFF_8001.
